// File: rtl/noc_pkt_pkg.sv
// Shared NoC packet types: field widths, packet layout and the
// output-register state encoding used by the injection arbiter.
package noc_pkt_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 7;
  localparam int PKT_W  = ADDR_W + DATA_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } pkt_t;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } out_state_e;

  function automatic pkt_t make_pkt(
    input logic [ADDR_W-1:0] addr,
    input logic [DATA_W-1:0] data
  );
    pkt_t p;
    p.addr = addr;
    p.data = data;
    return p;
  endfunction

endpackage

// File: rtl/packet_inject_arbiter_if.sv
// Requester-side and downstream-side handshake bundle of the
// packet injection arbiter.
interface packet_inject_arbiter_if
  import noc_pkt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = ADDR_W,
  parameter int DW   = DATA_W,
  localparam int PW  = AW + DW,
  localparam int IW  = $clog2(NREQ)
) ();

  logic [NREQ-1:0]    req_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    req_ready;
  logic               out_valid;
  logic [PW-1:0]      out_packet;
  logic               out_ready;
  logic [IW-1:0]      grant_id;

  modport master (
    output req_valid, req_addr, req_data, out_ready,
    input  req_ready, out_valid, out_packet, grant_id
  );

  modport slave (
    input  req_valid, req_addr, req_data, out_ready,
    output req_ready, out_valid, out_packet, grant_id
  );

endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first request at or above ptr,
// wrapping at N-1 -> 0.
module rr_arbiter #(
  parameter int N   = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  input  logic          en_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          any_o
);

  always_comb begin
    int s;
    logic [IW-1:0] idx;
    gnt_o     = '0;
    gnt_idx_o = '0;
    any_o     = |req_i;
    // Walk downward so the nearest hit after ptr is the last write.
    for (int k = N - 1; k >= 0; k--) begin
      s = int'(ptr_i) + k;
      if (s >= N) s = s - N;
      idx = IW'(s);
      if (req_i[idx]) gnt_idx_o = idx;
    end
    if (en_i && any_o) gnt_o[gnt_idx_o] = 1'b1;
  end

endmodule

// File: rtl/packet_inject_arbiter.sv
// Round-robin injection of NREQ address/data sources into one
// registered packet output with valid/ready drain.
module packet_inject_arbiter
  import noc_pkt_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int AW   = ADDR_W,
  parameter int DW   = DATA_W,
  localparam int PW  = AW + DW,
  localparam int IW  = $clog2(NREQ)
) (
  input logic CLK,
  input logic _RESET,
  packet_inject_arbiter_if.slave bus
);

  out_state_e    st_q, st_d;
  logic [PW-1:0] pkt_q, pkt_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] rr_q, rr_d;
  logic [IW-1:0] w;
  logic [NREQ-1:0] gnt;
  logic any, can_load, load;

  assign can_load = (st_q == S_EMPTY) | bus.out_ready;
  // Reset gates the grant so nothing is handed over while held.
  assign load = any & can_load & _RESET;

  rr_arbiter #(.N(NREQ)) u_arb (
    .req_i    (bus.req_valid),
    .ptr_i    (rr_q),
    .en_i     (can_load & _RESET),
    .gnt_o    (gnt),
    .gnt_idx_o(w),
    .any_o    (any)
  );

  assign bus.req_ready  = gnt;
  assign bus.out_valid  = (st_q == S_FULL);
  assign bus.out_packet = pkt_q;
  assign bus.grant_id   = gid_q;

  always_comb begin
    st_d  = st_q;
    pkt_d = pkt_q;
    gid_d = gid_q;
    rr_d  = rr_q;
    if (load) begin
      st_d  = S_FULL;
      pkt_d = {bus.req_addr[w*AW +: AW],
               bus.req_data[w*DW +: DW]};
      gid_d = w;
      rr_d  = (w == IW'(NREQ - 1)) ? '0 : w + 1'b1;
    end else if (st_q == S_FULL && bus.out_ready) begin
      st_d = S_EMPTY;
    end
  end

  always_ff @(posedge CLK or negedge _RESET) begin
    if (!_RESET) begin
      st_q  <= S_EMPTY;
      pkt_q <= '0;
      gid_q <= '0;
      rr_q  <= '0;
    end else begin
      st_q  <= st_d;
      pkt_q <= pkt_d;
      gid_q <= gid_d;
      rr_q  <= rr_d;
    end
  end

endmodule

// File: tb/tb_packet_inject_arbiter.sv
// Scenario bench for packet_inject_arbiter with a behavioural
// round-robin model and per-source packet scoreboard.
module tb_packet_inject_arbiter;
  import noc_pkt_pkg::*;

  localparam int N  = 4;
  localparam int AW = ADDR_W;
  localparam int DW = DATA_W;
  localparam int PW = AW + DW;

  logic CLK = 1'b0;
  logic rst_n = 1'b0;
  int n_checks = 0;
  int n_fail = 0;

  packet_inject_arbiter_if #(.NREQ(N), .AW(AW), .DW(DW)) bus ();

  packet_inject_arbiter #(.NREQ(N), .AW(AW), .DW(DW)) dut (
    .CLK   (CLK),
    ._RESET(rst_n),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  bit            m_valid;
  logic [PW-1:0] m_pkt;
  int            m_gid;
  int            m_ptr;
  logic [AW-1:0] a [N];
  logic [DW-1:0] d [N];
  logic [PW-1:0] sbq [N][$];

  task automatic model_reset();
    m_valid = 1'b0;
    m_pkt   = '0;
    m_gid   = 0;
    m_ptr   = 0;
    for (int i = 0; i < N; i++) sbq[i].delete();
  endtask

  task automatic set_src(input int i, input logic [AW-1:0] ad, input logic [DW-1:0] da);
    a[i] = ad;
    d[i] = da;
    bus.req_addr[i*AW +: AW] = ad;
    bus.req_data[i*DW +: DW] = da;
  endtask

  function automatic int winner();
    for (int k = 0; k < N; k++)
      if (bus.req_valid[(m_ptr + k) % N]) return (m_ptr + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] exp_ready();
    logic [N-1:0] r;
    int w;
    r = '0;
    w = winner();
    if (rst_n && w >= 0 && (!m_valid || bus.out_ready)) r[w] = 1'b1;
    return r;
  endfunction

  // Advance one clock; the model follows the rules at the rising edge.
  task automatic tick(output int g);
    int w;
    bit drain, ld;
    @(posedge CLK);
    g = -1;
    w = winner();
    drain = m_valid && bus.out_ready;
    ld = rst_n && w >= 0 && (!m_valid || bus.out_ready);
    if (!rst_n) begin
      model_reset();
    end else if (ld) begin
      m_pkt = make_pkt(a[w], d[w]);
      m_gid = w;
      m_valid = 1'b1;
      m_ptr = (w + 1) % N;
      g = w;
    end else if (drain) begin
      m_valid = 1'b0;
    end
    @(negedge CLK);
  endtask

  task automatic test_reset();
    int g;
    for (int i = 0; i < N; i++) set_src(i, AW'(i + 1), DW'(8 * i + 3));
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    rst_n = 1'b0;
    model_reset();
    for (int c = 0; c < 5; c++) begin
      tick(g);
      #1;
      n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bus.out_valid); end
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rst_ready: got %b want 0000", bus.req_ready); end
      n_checks++; if (bus.out_packet !== 11'h000) begin n_fail++; $display("FAIL rst_pkt: got %h want 000", bus.out_packet); end
    end
    rst_n = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rst_first_ready: got %b want 0001", bus.req_ready); end
    tick(g);
    #1;
    n_checks++; if (bus.grant_id !== 2'd0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rst_first_grant: got id=%0d v=%b want id=0 v=1", bus.grant_id, bus.out_valid); end
    n_checks++; if (bus.out_packet !== make_pkt(4'h1, 7'h03)) begin n_fail++; $display("FAIL rst_first_pkt: got %h want %h", bus.out_packet, make_pkt(4'h1, 7'h03)); end
  endtask

  task automatic test_single();
    int g;
    set_src(2, 4'hA, 7'h15);
    bus.req_valid = 4'b0100;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", bus.req_ready); end
    tick(g);
    bus.req_valid = '0;
    #1;
    n_checks++; if (bus.out_packet !== 11'h515) begin n_fail++; $display("FAIL single_pkt: got %h want 515", bus.out_packet); end
    n_checks++; if (bus.grant_id !== 2'd2 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_id: got id=%0d v=%b want id=2 v=1", bus.grant_id, bus.out_valid); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_idle_ready: got %b want 0000", bus.req_ready); end
    tick(g);
    #1;
    n_checks++; if (bus.out_valid !== 1'b0 || bus.out_packet !== 11'h515) begin n_fail++; $display("FAIL single_drain: got v=%b pkt=%h want v=0 pkt=515", bus.out_valid, bus.out_packet); end
  endtask

  task automatic test_round_robin();
    int g;
    int exp_id;
    exp_id = 3;
    bus.req_valid = '1;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_checks++; if (bus.req_ready !== exp_ready()) begin n_fail++; $display("FAIL rr_ready: got %b want %b", bus.req_ready, exp_ready()); end
      tick(g);
      #1;
      n_checks++; if (bus.grant_id !== 2'(exp_id) || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rr_seq: got id=%0d v=%b want id=%0d v=1", bus.grant_id, bus.out_valid, exp_id); end
      n_checks++; if (bus.out_packet !== m_pkt) begin n_fail++; $display("FAIL rr_pkt: got %h want %h", bus.out_packet, m_pkt); end
      if (g >= 0) set_src(g, AW'($urandom), DW'($urandom));
      exp_id = (exp_id + 1) % N;
    end
  endtask

  task automatic test_backpressure();
    int g;
    logic [PW-1:0] held;
    held = m_pkt;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      #1;
      n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL bp_ready: got %b want 0000", bus.req_ready); end
      n_checks++; if (bus.out_packet !== held || bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL bp_hold: got pkt=%h id=%0d want pkt=%h id=2", bus.out_packet, bus.grant_id, held); end
      tick(g);
    end
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL bp_resume_ready: got %b want 1000", bus.req_ready); end
    tick(g);
    #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.grant_id !== 2'd3) begin n_fail++; $display("FAIL bp_no_gap: got v=%b id=%0d want v=1 id=3", bus.out_valid, bus.grant_id); end
  endtask

  task automatic test_sparse();
    int g;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    tick(g);
    set_src(1, 4'h6, 7'h2A);
    set_src(3, 4'hC, 7'h51);
    bus.req_valid = 4'b0010;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL sp_prime: got %b want 0010", bus.req_ready); end
    tick(g);
    bus.req_valid = 4'b1010;
    #1;
    n_checks++; if (bus.req_ready !== 4'b1000) begin n_fail++; $display("FAIL sp_skip_ready: got %b want 1000", bus.req_ready); end
    tick(g);
    #1;
    n_checks++; if (bus.grant_id !== 2'd3 || bus.out_packet !== 11'h651) begin n_fail++; $display("FAIL sp_grant3: got id=%0d pkt=%h want id=3 pkt=651", bus.grant_id, bus.out_packet); end
    n_checks++; if (bus.req_ready !== 4'b0010) begin n_fail++; $display("FAIL sp_wrap_ready: got %b want 0010", bus.req_ready); end
    tick(g);
    #1;
    n_checks++; if (bus.grant_id !== 2'd1) begin n_fail++; $display("FAIL sp_grant1: got %0d want 1", bus.grant_id); end
    bus.req_valid = '0;
    repeat (4) tick(g);
    bus.req_valid = '1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0100) begin n_fail++; $display("FAIL sp_ptr_still: got %b want 0100", bus.req_ready); end
    tick(g);
    #1;
    n_checks++; if (bus.grant_id !== 2'd2) begin n_fail++; $display("FAIL sp_after_idle: got %0d want 2", bus.grant_id); end
  endtask

  task automatic test_reset_mid();
    int g;
    bus.req_valid = 4'b0001;
    bus.out_ready = 1'b1;
    tick(g);
    bus.req_valid = '1;
    bus.out_ready = 1'b0;
    #1;
    n_checks++; if (bus.out_valid !== 1'b1 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL rm_full: got v=%b id=%0d want v=1 id=0", bus.out_valid, bus.grant_id); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rm_async_drop: got %b want 0", bus.out_valid); end
    n_checks++; if (bus.req_ready !== 4'b0000) begin n_fail++; $display("FAIL rm_ready: got %b want 0000", bus.req_ready); end
    tick(g);
    tick(g);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    n_checks++; if (bus.req_ready !== 4'b0001) begin n_fail++; $display("FAIL rm_restart: got %b want 0001", bus.req_ready); end
    tick(g);
    #1;
    n_checks++; if (bus.grant_id !== 2'd0 || bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL rm_first: got id=%0d v=%b want id=0 v=1", bus.grant_id, bus.out_valid); end
  endtask

  task automatic test_random();
    int g;
    int w;
    logic [N-1:0] er;
    logic [PW-1:0] head;
    bus.req_valid = '0;
    bus.out_ready = 1'b1;
    tick(g);
    for (int i = 0; i < N; i++) sbq[i].delete();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!bus.req_valid[i] || i == g) begin
          set_src(i, AW'($urandom), DW'($urandom));
          bus.req_valid[i] = ($urandom % 2) == 0;
        end else if ($urandom % 8 == 0) begin
          bus.req_valid[i] = 1'b0;
        end
      end
      bus.out_ready = ($urandom % 4) != 0;
      #1;
      er = exp_ready();
      n_checks++; if (bus.req_ready !== er) begin n_fail++; $display("FAIL rnd_ready c=%0d: got %b want %b", c, bus.req_ready, er); end
      n_checks++; if (!$onehot0(bus.req_ready)) begin n_fail++; $display("FAIL rnd_onehot c=%0d: got %b want one-hot or zero", c, bus.req_ready); end
      n_checks++; if (bus.out_valid !== m_valid) begin n_fail++; $display("FAIL rnd_valid c=%0d: got %b want %b", c, bus.out_valid, m_valid); end
      if (m_valid) begin
        n_checks++; if (bus.out_packet !== m_pkt || bus.grant_id !== 2'(m_gid)) begin n_fail++; $display("FAIL rnd_out c=%0d: got pkt=%h id=%0d want pkt=%h id=%0d", c, bus.out_packet, bus.grant_id, m_pkt, m_gid); end
      end
      if (bus.out_valid === 1'b1 && bus.out_ready) begin
        n_checks++;
        if (sbq[bus.grant_id].size() == 0) begin
          n_fail++; $display("FAIL rnd_sb_empty c=%0d: got id=%0d with no offered packet", c, bus.grant_id);
        end else begin
          head = sbq[bus.grant_id].pop_front();
          if (bus.out_packet !== head) begin n_fail++; $display("FAIL rnd_sb c=%0d: got %h want %h", c, bus.out_packet, head); end
        end
      end
      w = winner();
      if (er != '0) sbq[w].push_back(make_pkt(a[w], d[w]));
      tick(g);
    end
  endtask

  initial begin
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_data  = '0;
    bus.out_ready = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_sparse();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
